// File: rtl/note_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer_if
// Brief    : Control/table/generator signal bundle for note_sequencer.
// Revision : 1.0
// ============================================================================
interface note_sequencer_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          i_tick;
  logic          i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [23:0]   i_wr_targetf;
  logic [1:0]    i_wr_wave;
  logic [15:0]   i_wr_dur_ms;
  logic [AW:0]   i_len;
  logic          i_start;
  logic          i_stop;
  logic [23:0]   o_targetf;
  logic [7:0]    o_wave;
  logic          o_pause;
  logic          o_busy;
  logic [AW-1:0] o_idx;
  logic          o_done;

  modport master (
    output i_tick, i_wr_en, i_wr_addr, i_wr_targetf, i_wr_wave, i_wr_dur_ms,
           i_len, i_start, i_stop,
    input  o_targetf, o_wave, o_pause, o_busy, o_idx, o_done
  );

  modport slave (
    input  i_tick, i_wr_en, i_wr_addr, i_wr_targetf, i_wr_wave, i_wr_dur_ms,
           i_len, i_start, i_stop,
    output o_targetf, o_wave, o_pause, o_busy, o_idx, o_done
  );
endinterface
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer
// Brief    : Steps a note table, timing notes and gaps on the 48 kHz tick.
//            Define SEQ_LOOP_EN to replay the table until stopped.
// Revision : 1.0
// ============================================================================
module note_sequencer #(
  parameter int DEPTH     = 16,
  parameter int GAP_TICKS = 480
) (
  input  logic            i_clk48,
  input  logic            i_rst48,
  note_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0] c_GAP_LAST   = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [5:0]    c_PRESC_LAST = 6'd47;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t        state_q;
  logic [AW:0]   len_q;
  logic [AW-1:0] idx_q;
  logic [15:0]   dur_q;
  logic [5:0]    presc_q;
  logic [15:0]   ms_q;
  logic [GW-1:0] gap_q;
  logic [23:0]   targetf_q;
  logic [1:0]    wave_q;
  logic          pause_q;
  logic          busy_q;
  logic          done_q;

  // Entry layout: {dur_ms[15:0], wave[1:0], targetf[23:0]}
  logic [41:0]   mem_q [DEPTH];
  logic [41:0]   rd_q;
  logic [AW-1:0] rd_addr_d;
  logic          last_d;
  logic          gap_end_d;
  logic          play_end_d;

  // Read address leads idx by one cycle so rd_q is valid during LOAD.
  always_comb begin
    last_d     = (({1'b0, idx_q} + (AW+1)'(1)) == len_q);
    gap_end_d  = (GAP_TICKS == 0) || (bus.i_tick && (gap_q == c_GAP_LAST));
    play_end_d = bus.i_tick && (presc_q == c_PRESC_LAST) && ((ms_q + 16'd1) == dur_q);
    case (state_q)
      S_GAP:          rd_addr_d = last_d ? '0 : idx_q + AW'(1);
      S_LOAD, S_PLAY: rd_addr_d = idx_q;
      default:        rd_addr_d = '0;
    endcase
  end

  always_ff @(posedge i_clk48) begin
    if (bus.i_wr_en && (state_q == S_IDLE)) begin
      mem_q[bus.i_wr_addr] <= {bus.i_wr_dur_ms, bus.i_wr_wave, bus.i_wr_targetf};
    end
    rd_q <= mem_q[rd_addr_d];
  end

  always_ff @(posedge i_clk48) begin
    if (i_rst48) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      dur_q     <= '0;
      presc_q   <= '0;
      ms_q      <= '0;
      gap_q     <= '0;
      targetf_q <= '0;
      wave_q    <= '0;
      pause_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            len_q <= bus.i_len;
            idx_q <= '0;
            if (bus.i_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_LOAD;
              busy_q  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          targetf_q <= rd_q[23:0];
          wave_q    <= rd_q[25:24];
          dur_q     <= rd_q[41:26];
          presc_q   <= '0;
          ms_q      <= '0;
          gap_q     <= '0;
          if (rd_q[41:26] == 16'd0) begin
            state_q <= S_GAP;
            pause_q <= 1'b1;
          end else begin
            state_q <= S_PLAY;
            pause_q <= 1'b0;
          end
        end
        S_PLAY: begin
          if (bus.i_tick) begin
            if (presc_q == c_PRESC_LAST) begin
              presc_q <= '0;
              ms_q    <= ms_q + 16'd1;
            end else begin
              presc_q <= presc_q + 6'd1;
            end
          end
          if (play_end_d) begin
            pause_q <= 1'b1;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_end_d) begin
            if (last_d) begin
`ifdef SEQ_LOOP_EN
              idx_q   <= '0;
              done_q  <= 1'b1;
              state_q <= S_LOAD;
`else
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
`endif
            end else begin
              idx_q   <= idx_q + AW'(1);
              state_q <= S_LOAD;
            end
          end else if (bus.i_tick) begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Abort wins over any transition decided above, including a natural finish.
      if (bus.i_stop && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        pause_q <= 1'b1;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end
    end
  end

  assign bus.o_targetf = targetf_q;
  assign bus.o_wave    = {6'b0, wave_q};
  assign bus.o_pause   = pause_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_idx     = idx_q;
  assign bus.o_done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_sequencer
// Brief    : Directed self-checking bench for note_sequencer (tick every 4 clocks).
// Revision : 1.0
// ============================================================================
module tb_note_sequencer;
  localparam int DEPTH     = 16;
  localparam int GAP_TICKS = 480;
  localparam int AW        = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  note_sequencer_if #(.DEPTH(DEPTH)) bus ();

  note_sequencer #(.DEPTH(DEPTH), .GAP_TICKS(GAP_TICKS)) dut (
    .i_clk48 (clk),
    .i_rst48 (rst),
    .bus     (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit tick_en = 1'b0;
  int n440, n880, nother, ngap, ndone, last_idx;
  int idx_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Tick is high for one cycle out of four.
  initial begin
    bus.i_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.i_tick = tick_en && (cyc % 4 == 0);
    end
  end

  // Tick/done/idx bookkeeping sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_done) ndone++;
      if (bus.i_tick && bus.o_busy) begin
        if (bus.o_pause) ngap++;
        else if (bus.o_targetf == 24'd440 && bus.o_wave == 8'd0) n440++;
        else if (bus.o_targetf == 24'd880 && bus.o_wave == 8'd2) n880++;
        else nother++;
      end
      if (bus.o_busy && int'(bus.o_idx) != last_idx) begin
        idx_log.push_back(int'(bus.o_idx));
        last_idx = int'(bus.o_idx);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    n440 = 0; n880 = 0; nother = 0; ngap = 0; ndone = 0; last_idx = -1;
    idx_log.delete();
  endtask

  task automatic wr(input int addr, input int f, input int w, input int d);
    bus.i_wr_en      = 1'b1;
    bus.i_wr_addr    = AW'(addr);
    bus.i_wr_targetf = 24'(f);
    bus.i_wr_wave    = 2'(w);
    bus.i_wr_dur_ms  = 16'(d);
    step();
    bus.i_wr_en      = 1'b0;
  endtask

  // Start right after a tick so no tick lands in the first LOAD cycle.
  task automatic start_seq(input int len);
    while (cyc % 4 != 1) step();
    bus.i_len   = (AW+1)'(len);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.o_busy && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_targetf = '0;
    bus.i_wr_wave = '0; bus.i_wr_dur_ms = '0; bus.i_len = '0;
    bus.i_start = 1'b0; bus.i_stop = 1'b0;
    clear_mon();
    tick_en = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_targetf", 32'(bus.o_targetf), 32'd0);
    check("rst_wave",    32'(bus.o_wave),    32'd0);
    check("rst_pause",   32'(bus.o_pause),   32'd1);
    check("rst_busy",    32'(bus.o_busy),    32'd0);
    check("rst_idx",     32'(bus.o_idx),     32'd0);
    check("rst_done",    32'(bus.o_done),    32'd0);
    step();
    rst = 1'b0;
    step();

    // Two-note run; a write and a start issued mid-run must be ignored.
    wr(0, 440, 0, 2);
    wr(1, 880, 2, 1);
    clear_mon();
    start_seq(2);
    check("t1_busy_on", 32'(bus.o_busy), 32'd1);
    begin
      int n = 0;
      while (ngap < 10 && n < 2000) begin step(); n++; end
      check("t1_gap_reach", 32'(n < 2000), 32'd1);
    end
    wr(1, 1234, 3, 5);
    bus.i_len = 1; bus.i_start = 1'b1; step(); bus.i_start = 1'b0;
    wait_idle("t1_timeout", 6000);
    check("t1_n440",    32'(n440),   32'd96);
    check("t1_n880",    32'(n880),   32'd48);
    check("t1_nother",  32'(nother), 32'd0);
    check("t1_ngap",    32'(ngap),   32'd960);
    check("t1_ndone",   32'(ndone),  32'd1);
    check("t1_busy",    32'(bus.o_busy),    32'd0);
    check("t1_pause",   32'(bus.o_pause),   32'd1);
    check("t1_targetf", 32'(bus.o_targetf), 32'd880);
    check("t1_wave",    32'(bus.o_wave),    32'd2);
    check("t1_idx",     32'(bus.o_idx),     32'd1);
    check("t1_log_n",   32'(idx_log.size()), 32'd2);
    check("t1_log0",    32'(idx_log[0]), 32'd0);
    check("t1_log1",    32'(idx_log[1]), 32'd1);

    // Zero-length start.
    clear_mon();
    start_seq(0);
    check("t2_done",  32'(bus.o_done),  32'd1);
    check("t2_busy",  32'(bus.o_busy),  32'd0);
    check("t2_pause", 32'(bus.o_pause), 32'd1);
    step();
    check("t2_done_off", 32'(bus.o_done), 32'd0);
    check("t2_busy_off", 32'(bus.o_busy), 32'd0);

    // Rest note: only the gap elapses.
    wr(0, 1000, 1, 0);
    clear_mon();
    start_seq(2);
    repeat (10) step();
    check("t3_targetf", 32'(bus.o_targetf), 32'd1000);
    check("t3_wave",    32'(bus.o_wave),    32'd1);
    check("t3_pause",   32'(bus.o_pause),   32'd1);
    check("t3_idx",     32'(bus.o_idx),     32'd0);
    wait_idle("t3_timeout", 6000);
    check("t3_nother", 32'(nother), 32'd0);
    check("t3_n880",   32'(n880),   32'd48);
    check("t3_ngap",   32'(ngap),   32'd960);
    check("t3_ndone",  32'(ndone),  32'd1);
    check("t3_idx_end", 32'(bus.o_idx), 32'd1);

    // Stop mid-PLAY together with start, then restart.
    wr(0, 440, 0, 2);
    clear_mon();
    start_seq(2);
    begin
      int n = 0;
      while (n440 < 20 && n < 500) begin step(); n++; end
      check("t4_play_reach", 32'(n < 500), 32'd1);
    end
    check("t4_pause_play", 32'(bus.o_pause), 32'd0);
    bus.i_stop = 1'b1; bus.i_start = 1'b1; bus.i_len = 2;
    step();
    bus.i_stop = 1'b0; bus.i_start = 1'b0;
    check("t4_busy", 32'(bus.o_busy),  32'd0);
    check("t4_pause", 32'(bus.o_pause), 32'd1);
    check("t4_done", 32'(bus.o_done),  32'd0);
    repeat (5) step();
    check("t4_busy_hold", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    #1;
    check("t4_ndone", 32'(ndone), 32'd0);
    clear_mon();
    start_seq(2);
    check("t4_re_idx", 32'(bus.o_idx), 32'd0);
    repeat (3) step();
    check("t4_re_pause",   32'(bus.o_pause),   32'd0);
    check("t4_re_targetf", 32'(bus.o_targetf), 32'd440);
    wait_idle("t4_timeout", 6000);
    check("t4_n440",  32'(n440),  32'd96);
    check("t4_n880",  32'(n880),  32'd48);
    check("t4_ndone", 32'(ndone), 32'd1);

    // Reset mid-sequence; table survives.
    start_seq(2);
    repeat (20) step();
    rst = 1'b1;
    step();
    check("t5_targetf", 32'(bus.o_targetf), 32'd0);
    check("t5_wave",    32'(bus.o_wave),    32'd0);
    check("t5_pause",   32'(bus.o_pause),   32'd1);
    check("t5_busy",    32'(bus.o_busy),    32'd0);
    check("t5_idx",     32'(bus.o_idx),     32'd0);
    rst = 1'b0;
    step();
    start_seq(2);
    repeat (3) step();
    check("t5_targetf_kept", 32'(bus.o_targetf), 32'd440);
    bus.i_stop = 1'b1; step(); bus.i_stop = 1'b0;
    check("t5_stop_busy", 32'(bus.o_busy), 32'd0);

`ifdef SEQ_LOOP_EN
    clear_mon();
    start_seq(2);
    begin
      int n = 0;
      while (ndone < 2 && n < 12000) begin step(); n++; end
      check("t6_wrap_reach", 32'(n < 12000), 32'd1);
    end
    check("t6_busy",  32'(bus.o_busy), 32'd1);
    check("t6_log_n", 32'(idx_log.size() >= 4), 32'd1);
    check("t6_log0",  32'(idx_log[0]), 32'd0);
    check("t6_log1",  32'(idx_log[1]), 32'd1);
    check("t6_log2",  32'(idx_log[2]), 32'd0);
    check("t6_log3",  32'(idx_log[3]), 32'd1);
    bus.i_stop = 1'b1; step(); bus.i_stop = 1'b0;
    check("t6_stop_busy", 32'(bus.o_busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
